// File: rtl/lane_tx_scheduler_pkg.sv
// Shared PHY lane definitions: comma byte, lane state encoding and default training length.
// Also used by the serial-to-parallel and parallel-to-serial blocks.
package lane_tx_scheduler_pkg;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int TRAIN_BC_DEFAULT = 4;

  typedef enum logic [1:0] {
    TRAIN       = 2'd0,
    WAIT_ACTIVE = 2'd1,
    RUN         = 2'd2
  } lane_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from the valids and the last-served
// pointer, and each grant is already a completed handshake.
module rr_arbiter2 (
  input  logic clk_4f,
  input  logic reset,
  input  logic enable,
  input  logic valid_0,
  input  logic valid_1,
  output logic grant_0,
  output logic grant_1
);

  logic last;

  always_comb begin
    grant_0 = enable && valid_0 && (!valid_1 || last);
    grant_1 = enable && valid_1 && (!valid_0 || !last);
  end

  // last resets to 1 so that requester 0 wins the first contention
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      last <= 1'b1;
    end else if (grant_0) begin
      last <= 1'b0;
    end else if (grant_1) begin
      last <= 1'b1;
    end
  end

endmodule

// File: rtl/lane_tx_scheduler.sv
// Transmit-side lane controller. It trains the link with commas, waits for the far end to
// become active, then arbitrates two byte requesters and inserts idle and skip commas.
module lane_tx_scheduler
  import lane_tx_scheduler_pkg::*;
#(
  parameter int TRAIN_BC    = TRAIN_BC_DEFAULT,
  parameter int TIMEOUT     = 64,
  parameter int SKIP_PERIOD = 32
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       link_active,
  input  logic       req_valid_0,
  input  logic       req_valid_1,
  input  logic [7:0] req_data_0,
  input  logic [7:0] req_data_1,
  output logic       req_ready_0,
  output logic       req_ready_1,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       link_up,
  output logic       err_reserved
);

  localparam int TRW = $clog2(TRAIN_BC);
  localparam int TOW = $clog2(TIMEOUT);
  localparam int SKW = $clog2(SKIP_PERIOD);

  localparam logic [TRW-1:0] TRAIN_LAST   = TRW'(TRAIN_BC - 1);
  localparam logic [TOW-1:0] TIMEOUT_LAST = TOW'(TIMEOUT - 1);
  localparam logic [SKW-1:0] SKIP_LAST    = SKW'(SKIP_PERIOD - 1);

  lane_state_t    state;
  logic [TRW-1:0] train_cnt;
  logic [TOW-1:0] timeout_cnt;
  logic [SKW-1:0] skip_cnt;

  logic       grant_en;
  logic       grant_0;
  logic       grant_1;
  logic       any_hs;
  logic [7:0] sel_data;

  // Grants are withheld in the skip slot, on loss of activity and while reset is high.
  assign grant_en = (state == RUN) && link_active && (skip_cnt != SKIP_LAST) && !reset;

  rr_arbiter2 u_arb (
    .clk_4f  (clk_4f),
    .reset   (reset),
    .enable  (grant_en),
    .valid_0 (req_valid_0),
    .valid_1 (req_valid_1),
    .grant_0 (grant_0),
    .grant_1 (grant_1)
  );

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;
  assign any_hs      = grant_0 || grant_1;
  assign sel_data    = grant_0 ? req_data_0 : req_data_1;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state        <= TRAIN;
      train_cnt    <= '0;
      timeout_cnt  <= '0;
      skip_cnt     <= '0;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      link_up      <= 1'b0;
      err_reserved <= 1'b0;
    end else begin
      tx_data      <= COMMA;
      tx_valid     <= 1'b0;
      link_up      <= 1'b0;
      err_reserved <= 1'b0;
      case (state)
        TRAIN: begin
          if (train_cnt == TRAIN_LAST) begin
            train_cnt   <= '0;
            timeout_cnt <= '0;
            state       <= WAIT_ACTIVE;
          end else begin
            train_cnt <= train_cnt + 1'b1;
          end
        end
        WAIT_ACTIVE: begin
          if (link_active) begin
            skip_cnt    <= '0;
            timeout_cnt <= '0;
            state       <= RUN;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            timeout_cnt <= '0;
            train_cnt   <= '0;
            state       <= TRAIN;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!link_active) begin
            train_cnt <= '0;
            skip_cnt  <= '0;
            state     <= TRAIN;
          end else begin
            link_up  <= 1'b1;
            skip_cnt <= (skip_cnt == SKIP_LAST) ? '0 : skip_cnt + 1'b1;
            // A reserved byte is consumed but replaced by an idle comma.
            if (any_hs) begin
              if (sel_data == COMMA) begin
                err_reserved <= 1'b1;
              end else begin
                tx_data  <= sel_data;
                tx_valid <= 1'b1;
              end
            end
          end
        end
        default: state <= TRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Directed bench for lane_tx_scheduler: training, traffic with skip slots, table vectors,
// timeout retrain, link loss and reset.
module tb_lane_tx_scheduler;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       link_active;
  logic       req_valid_0, req_valid_1;
  logic [7:0] req_data_0, req_data_1;
  logic       req_ready_0, req_ready_1;
  logic [7:0] tx_data;
  logic       tx_valid, link_up, err_reserved;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic       la;
    logic       er0, er1;
    logic [7:0] etx;
    logic       ev, eerr, eup;
  } vec_t;

  vec_t vecs[11];

  lane_tx_scheduler dut (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .link_active  (link_active),
    .req_valid_0  (req_valid_0),
    .req_valid_1  (req_valid_1),
    .req_data_0   (req_data_0),
    .req_data_1   (req_data_1),
    .req_ready_0  (req_ready_0),
    .req_ready_1  (req_ready_1),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .link_up      (link_up),
    .err_reserved (err_reserved)
  );

  always #5 clk_4f = ~clk_4f;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic exp_up);
    chk({tag, " tx_data"}, tx_data, 8'hBC);
    chk({tag, " tx_valid"}, {7'd0, tx_valid}, 8'd0);
    chk({tag, " link_up"}, {7'd0, link_up}, {7'd0, exp_up});
  endtask

  initial begin
    logic       exp_last;
    logic       g;
    logic [7:0] exp_tx;
    logic       exp_v;

    //                v0    v1    d0     d1     la    er0   er1   etx    ev    err   up
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 8'hBC, 8'h00, 1'b1, 1'b1, 1'b0, 8'hBC, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 8'hBC, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'hBC, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'hBC, 8'h44, 1'b1, 1'b1, 1'b0, 8'hBC, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'hBC, 1'b1, 1'b0, 1'b1, 8'hBC, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b0, 1'b0, 1'b0};

    // Reset with link_active already high and both requesters valid
    reset = 1'b1; link_active = 1'b1;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_data_0 = 8'h11; req_data_1 = 8'h22;
    tick(); tick();
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset tx_valid", {7'd0, tx_valid}, 8'd0);
    chk("reset link_up", {7'd0, link_up}, 8'd0);
    chk("reset err_reserved", {7'd0, err_reserved}, 8'd0);
    chk("reset ready_0", {7'd0, req_ready_0}, 8'd0);
    chk("reset ready_1", {7'd0, req_ready_1}, 8'd0);
    reset = 1'b0;

    for (int e = 1; e <= 4; e++) begin
      tick();
      chk_idle($sformatf("train e%0d", e), 1'b0);
      chk($sformatf("train e%0d ready_0", e), {7'd0, req_ready_0}, 8'd0);
      chk($sformatf("train e%0d ready_1", e), {7'd0, req_ready_1}, 8'd0);
    end
    tick();
    chk_idle("run entry e5", 1'b0);
    chk("run entry ready_0", {7'd0, req_ready_0}, 8'd1);
    chk("run entry ready_1", {7'd0, req_ready_1}, 8'd0);

    // Sustained both-valid traffic: alternation with one skip idle every 32 RUN cycles
    exp_last = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if ((c % 32) == 31) begin
        exp_tx = 8'hBC; exp_v = 1'b0;
      end else begin
        g = exp_last ? 1'b0 : 1'b1;
        exp_last = g;
        exp_tx = g ? 8'h22 : 8'h11; exp_v = 1'b1;
      end
      tick();
      chk($sformatf("traffic c%0d tx_data", c), tx_data, exp_tx);
      chk($sformatf("traffic c%0d tx_valid", c), {7'd0, tx_valid}, {7'd0, exp_v});
      chk($sformatf("traffic c%0d link_up", c), {7'd0, link_up}, 8'd1);
    end

    // Table vectors: RUN cycles 70..80, skip counter 6..16
    for (int i = 0; i < 11; i++) begin
      req_valid_0 = vecs[i].v0; req_valid_1 = vecs[i].v1;
      req_data_0 = vecs[i].d0;  req_data_1 = vecs[i].d1;
      link_active = vecs[i].la;
      #1;
      chk($sformatf("vec%0d ready_0", i), {7'd0, req_ready_0}, {7'd0, vecs[i].er0});
      chk($sformatf("vec%0d ready_1", i), {7'd0, req_ready_1}, {7'd0, vecs[i].er1});
      tick();
      chk($sformatf("vec%0d tx_data", i), tx_data, vecs[i].etx);
      chk($sformatf("vec%0d tx_valid", i), {7'd0, tx_valid}, {7'd0, vecs[i].ev});
      chk($sformatf("vec%0d err_reserved", i), {7'd0, err_reserved}, {7'd0, vecs[i].eerr});
      chk($sformatf("vec%0d link_up", i), {7'd0, link_up}, {7'd0, vecs[i].eup});
    end

    // link_active stays low: 4 TRAIN cycles, 64 WAIT_ACTIVE cycles, then back in TRAIN
    for (int e = 0; e < 68; e++) begin
      tick();
      chk_idle($sformatf("timeout e%0d", e), 1'b0);
      chk($sformatf("timeout e%0d ready_0", e), {7'd0, req_ready_0}, 8'd0);
      chk($sformatf("timeout e%0d ready_1", e), {7'd0, req_ready_1}, 8'd0);
    end
    link_active = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk_idle($sformatf("retrain e%0d", e), 1'b0);
    end
    tick();
    chk_idle("retrain e6", 1'b1);

    // One payload byte, then link loss, then reset in the middle of TRAIN
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_data_0 = 8'h11; req_data_1 = 8'h22;
    #1;
    chk("loss pre ready_0", {7'd0, req_ready_0}, 8'd1);
    tick();
    chk("loss pre tx_data", tx_data, 8'h11);
    link_active = 1'b0;
    #1;
    chk("loss ready_0", {7'd0, req_ready_0}, 8'd0);
    chk("loss ready_1", {7'd0, req_ready_1}, 8'd0);
    tick();
    chk_idle("loss edge", 1'b0);
    tick();
    chk_idle("train before reset", 1'b0);
    reset = 1'b1;
    link_active = 1'b1;
    #1;
    chk("reset mid-train ready_0", {7'd0, req_ready_0}, 8'd0);
    chk("reset mid-train ready_1", {7'd0, req_ready_1}, 8'd0);
    tick();
    chk("post reset tx_data", tx_data, 8'h00);
    chk("post reset tx_valid", {7'd0, tx_valid}, 8'd0);
    chk("post reset link_up", {7'd0, link_up}, 8'd0);
    chk("post reset err_reserved", {7'd0, err_reserved}, 8'd0);
    reset = 1'b0;
    tick();
    chk_idle("first edge after reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_tx_scheduler.md
# lane_tx_scheduler

Transmit-side controller for one PCI physical-layer lane, running on the byte clock in front of the parallel-to-serial converter. It trains the link with 0xBC comma bytes until the far-end serial-to-parallel converter reports active. It then round-robin-arbitrates two byte requesters onto the lane and inserts 0xBC idle/skip bytes whenever no data is sent. It retrains automatically on loss of activity or training timeout.

## Interface
- TRAIN_BC, 4: number of consecutive 0xBC bytes sent in TRAIN before entering WAIT_ACTIVE.
- TIMEOUT, 64: cycles allowed in WAIT_ACTIVE before returning to TRAIN.
- SKIP_PERIOD, 32: in RUN, one forced 0xBC slot every SKIP_PERIOD cycles.
- clk_4f  input  1  byte clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- link_active  input  1  active flag from the far-end serial-to-parallel converter.
- req_valid_0, req_valid_1  input  1  requester has a byte.
- req_data_0, req_data_1  input  8  requester byte.
- req_ready_0, req_ready_1  output  1  combinational grant; a handshake occurs when valid and ready are both 1.
- tx_data  output  8  byte to the parallel-to-serial converter (registered).
- tx_valid  output  1  1 = tx_data is payload; 0 = tx_data is 0xBC idle.
- link_up  output  1  registered; 1 only in RUN.
- err_reserved  output  1  one-cycle pulse when an accepted byte equals 0xBC.

## Operation
- Three states, encoded 2 bits: TRAIN=0, WAIT_ACTIVE=1, RUN=2.
- **TRAIN:** tx_data=0xBC, tx_valid=0, both readies 0. The train counter increments each cycle. After TRAIN_BC bytes have been emitted, go to WAIT_ACTIVE.
- **WAIT_ACTIVE:** keep sending 0xBC, readies 0, timeout counter increments.
  - link_active=1 → RUN; clear the skip counter.
  - Counter reaches TIMEOUT-1 with link_active=0 → TRAIN; clear counters.
- **RUN:**
  - link_up=1.
  - link_active=0 sampled → TRAIN next cycle. Readies drop combinationally in that same cycle, and no handshake is allowed in that cycle.
- **Skip slot:** the skip counter counts 0..SKIP_PERIOD-1 and wraps. When it equals SKIP_PERIOD-1, there is no grant that cycle; the next tx_data is 0xBC with tx_valid=0.
- **Arbitration:** the last-served pointer `last` resets to 1, so requester 0 wins first.
  - Only one requester valid → it is granted.
  - Both valid → the one not equal to `last` is granted.
  - `last` updates only on a handshake.
- **Transmit:**
  - Handshake → next cycle tx_data=granted byte, tx_valid=1.
  - No handshake → tx_data=0xBC, tx_valid=0.
- **Reserved byte:** an accepted byte equal to 0xBC is consumed but not sent. The block transmits an idle 0xBC with tx_valid=0 and pulses err_reserved, because the receiver cannot carry 0xBC as data.
- **Reset values:** state=TRAIN, tx_data=0x00, tx_valid=0, link_up=0, err_reserved=0, all counters 0, last=1. Reset during RUN discards any pending grant.

## Timing
- Handshake to tx_data: 1 cycle.
- req_ready_x depends on state, the skip counter, `last`, link_active and both valids. Requesters must not derive valid from ready.
- After reset deassertion: the first 0xBC appears on the first edge. WAIT_ACTIVE is entered after TRAIN_BC edges.
- With link_active held 1, RUN is entered at reset+TRAIN_BC+1 and link_up rises on the edge after entering RUN.
- Sustained both-valid traffic: payload alternates 0,1,0,1. Exactly one idle appears per SKIP_PERIOD cycles.
- The last cycle of RUN (link_active=0) produces an idle. link_up falls on the next edge.
- Counter widths: $clog2 of the respective parameter. Parameters must be at least 2.

## Structure
- Shared PHY package holds:
  - COMMA = 8'hBC;
  - state encoding constants TRAIN/WAIT_ACTIVE/RUN;
  - default TRAIN_BC.
- These constants are shared with the serial-to-parallel and parallel-to-serial blocks.
- One sub-module: rr_arbiter2 (combinational grant from valids and `last`, plus the registered `last` pointer). The FSM, counters and output register stay in lane_tx_scheduler.

## Test plan
- Reset, link_active=1 from start → 4 bytes of 0xBC in TRAIN, then RUN. link_up=1 at cycle 6. No ready before RUN.
- link_active=0 for 64 cycles in WAIT_ACTIVE → return to TRAIN. The 0xBC stream continues and link_up stays 0.
- RUN, both requesters always valid with data 0x11/0x22 → tx_data sequence 0x11,0x22,0x11,… with one 0xBC/tx_valid=0 every 32 cycles.
- RUN, only requester 1 valid with 0x5A → granted every non-skip cycle. tx_data=0x5A, tx_valid=1.
- Requester 0 sends 0xBC → req_ready_0=1, then err_reserved pulses once and tx_valid=0 next cycle.
- link_active drops mid-traffic, then reset asserted mid-TRAIN → readies 0 immediately. tx idle, link_up 0 next edge. After reset, all outputs are at their reset values.
